// File: rtl/flash_loader.sv
// flash_loader -- copies len_words 32-bit words from SPI flash into memory.
//
// Sequence: READ_CMD, three address bytes (MSB first), then 8'h00 dummy
// bytes clocked out four at a time.  Each group of four received bytes is
// packed little-endian into one word and written to memory, with the
// destination address stepping by 4.  The flash keeps streaming between
// words, so the command is issued only once per copy.
//
// Ports
//   clk, resetq                 clock, async active-low reset
//   start, abort                copy request / early stop request
//   src_addr, dst_addr,         copy parameters, sampled on accepted start
//   len_words
//   busy, done, aborted         status (done is a one-cycle pulse)
//   spi_we, spi_di              byte strobe / byte to send to spicore
//   spi_do, spi_ready           received byte / spicore idle
//   spi_ss_reset                one-cycle pulse releasing flash CS
//   mem_addr, mem_wdata,        destination write port; the write is held
//   mem_wmask, mem_wbusy        while mem_wbusy is high
module flash_loader #(
   parameter logic [7:0]  READ_CMD = 8'h03,
   parameter int unsigned LEN_W    = 16
) (
   input  logic             clk,
   input  logic             resetq,
   input  logic             start,
   input  logic             abort,
   input  logic [23:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len_words,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             spi_we,
   output logic [7:0]       spi_di,
   input  logic [7:0]       spi_do,
   input  logic             spi_ready,
   output logic             spi_ss_reset,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wmask,
   input  logic             mem_wbusy
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_A2, S_A1, S_A0, S_DATA, S_WRITE, S_FINISH
   } state_t;

   // Per-byte handshake: ISSUE waits for spi_ready and strobes spi_we,
   // SKIP is the cycle after the strobe (spi_ready not yet meaningful),
   // WAIT ends on the first spi_ready=1, which is when spi_do is valid.
   typedef enum logic [1:0] {PH_ISSUE, PH_SKIP, PH_WAIT} phase_t;

   state_t           state_q, state_d;
   phase_t           ph_q, ph_d;
   logic [23:0]      src_q, src_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      word_q, word_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [1:0]       bcnt_q, bcnt_d;
   logic             abort_q, abort_d;
   logic             sent_q, sent_d;
   logic             done_q, done_d;
   logic             ss_q, ss_d;
   logic             aborted_q, aborted_d;

   logic in_byte;
   logic stop;

   assign in_byte = (state_q == S_CMD) || (state_q == S_A2) || (state_q == S_A1) ||
                    (state_q == S_A0)  || (state_q == S_DATA);
   // An abort seen this cycle acts immediately, without waiting for the latch.
   assign stop    = abort_q | abort;

   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign aborted      = aborted_q;
   assign spi_ss_reset = ss_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = word_q;
   assign mem_wmask    = (state_q == S_WRITE) ? 4'hF : 4'h0;
   assign spi_we       = in_byte && (ph_q == PH_ISSUE) && spi_ready && !stop;

   always_comb begin
      spi_di = 8'h00;
      case (state_q)
         S_CMD:   spi_di = READ_CMD;
         S_A2:    spi_di = src_q[23:16];
         S_A1:    spi_di = src_q[15:8];
         S_A0:    spi_di = src_q[7:0];
         default: spi_di = 8'h00;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      src_d     = src_q;
      addr_d    = addr_q;
      word_d    = word_q;
      rem_d     = rem_q;
      bcnt_d    = bcnt_q;
      abort_d   = abort_q;
      sent_d    = sent_q;
      done_d    = (state_q == S_FINISH);
      ss_d      = (state_q == S_FINISH) && sent_q;
      aborted_d = aborted_q | ((state_q == S_FINISH) && abort_q);

      if ((in_byte || (state_q == S_WRITE)) && abort)
         abort_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               abort_d = 1'b0;
               sent_d  = 1'b0;
               if (len_words == '0) begin
                  state_d = S_FINISH;
               end else begin
                  src_d     = src_addr;
                  addr_d    = dst_addr;
                  rem_d     = len_words;
                  bcnt_d    = 2'd0;
                  ph_d      = PH_ISSUE;
                  aborted_d = 1'b0;
                  state_d   = S_CMD;
               end
            end
         end
         S_CMD, S_A2, S_A1, S_A0, S_DATA: begin
            case (ph_q)
               PH_ISSUE: begin
                  if (stop) begin
                     state_d = S_FINISH;
                  end else if (spi_ready) begin
                     ph_d   = PH_SKIP;
                     sent_d = 1'b1;
                  end
               end
               PH_SKIP: ph_d = PH_WAIT;
               default: begin
                  if (spi_ready) begin
                     ph_d = PH_ISSUE;
                     if (state_q == S_DATA) begin
                        word_d = {spi_do, word_q[31:8]};
                        bcnt_d = bcnt_q + 2'd1;
                     end
                     // A partially received word is dropped on abort.
                     if (stop) begin
                        state_d = S_FINISH;
                     end else begin
                        case (state_q)
                           S_CMD:   state_d = S_A2;
                           S_A2:    state_d = S_A1;
                           S_A1:    state_d = S_A0;
                           S_A0:    state_d = S_DATA;
                           default: if (bcnt_q == 2'd3) state_d = S_WRITE;
                        endcase
                     end
                  end
               end
            endcase
         end
         S_WRITE: begin
            if (!mem_wbusy) begin
               addr_d = addr_q + 32'd4;
               rem_d  = rem_q - LEN_W'(1);
               if (stop || (rem_q == LEN_W'(1))) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_DATA;
                  ph_d    = PH_ISSUE;
               end
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_q   <= S_IDLE;
         ph_q      <= PH_ISSUE;
         src_q     <= '0;
         addr_q    <= '0;
         word_q    <= '0;
         rem_q     <= '0;
         bcnt_q    <= '0;
         abort_q   <= 1'b0;
         sent_q    <= 1'b0;
         done_q    <= 1'b0;
         ss_q      <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         src_q     <= src_d;
         addr_q    <= addr_d;
         word_q    <= word_d;
         rem_q     <= rem_d;
         bcnt_q    <= bcnt_d;
         abort_q   <= abort_d;
         sent_q    <= sent_d;
         done_q    <= done_d;
         ss_q      <= ss_d;
         aborted_q <= aborted_d;
      end
   end

endmodule

// File: tb/tb_flash_loader.sv
// Self-checking bench for flash_loader: a spicore/flash model, a memory
// model with controllable stall, a monitor, and one task per scenario.
module tb_flash_loader;
   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             resetq = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [23:0]      src_addr = '0;
   logic [31:0]      dst_addr = '0;
   logic [LEN_W-1:0] len_words = '0;
   logic             busy, done, aborted, spi_we, spi_ss_reset;
   logic [7:0]       spi_di, spi_do;
   logic             spi_ready, mem_wbusy;
   logic [31:0]      mem_addr, mem_wdata;
   logic [3:0]       mem_wmask;

   flash_loader #(.READ_CMD(8'h03), .LEN_W(LEN_W)) dut (
      .clk(clk), .resetq(resetq), .start(start), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
      .busy(busy), .done(done), .aborted(aborted),
      .spi_we(spi_we), .spi_di(spi_di), .spi_do(spi_do), .spi_ready(spi_ready),
      .spi_ss_reset(spi_ss_reset),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_wbusy(mem_wbusy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // environment state shared by models and tests
   logic [23:0] fl_base = '0;
   logic [7:0]  fl_seed = '0;
   logic [23:0] fl_addr = '0;
   bit          spi_slow = 1'b0;
   bit          wb_rand  = 1'b0;
   int          stall_left = 0;
   logic [7:0]  spi_log[$];
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          done_cnt = 0, ss_cnt = 0, we_cnt = 0, wm_cycles = 0, unstable = 0;
   logic        ab_at_done = 1'b0;

   // flash contents
   function automatic logic [7:0] fb(input logic [23:0] a);
      logic [23:0] off;
      off = a - fl_base;
      return 8'((off + 24'd1) * 24'h11) ^ fl_seed;
   endfunction

   // spicore + flash: records every byte sent; after the command and three
   // address bytes, byte n returns the flash byte at fl_addr + (n-4).
   initial begin : spi_model
      logic       we_s;
      logic [7:0] resp;
      int         sdly;
      spi_ready = 1'b1; spi_do = 8'h00; sdly = 0; resp = 8'h00;
      forever begin
         @(negedge clk);
         we_s = spi_we & resetq;
         if (we_s) begin
            resp = (spi_log.size() >= 4) ? fb(fl_addr + 24'(spi_log.size() - 4)) : 8'hFF;
            spi_log.push_back(spi_di);
         end
         @(posedge clk); #1;
         if (!resetq) begin
            spi_ready = 1'b1; sdly = 0;
         end else if (we_s) begin
            spi_do    = resp;
            sdly      = spi_slow ? int'($urandom_range(0, 3)) : 0;
            spi_ready = (sdly == 0);
         end else if (sdly > 0) begin
            sdly = sdly - 1;
            if (sdly == 0) spi_ready = 1'b1;
         end
      end
   end

   // memory stall: stall_left holds busy high across that many write cycles
   initial begin : mem_model
      logic wm_s;
      mem_wbusy = 1'b0;
      forever begin
         @(negedge clk);
         wm_s = (mem_wmask == 4'hF);
         @(posedge clk); #1;
         if (stall_left > 0 && wm_s) stall_left = stall_left - 1;
         mem_wbusy = (stall_left > 0) || (wb_rand && $urandom_range(0, 2) == 0);
      end
   end

   initial begin : monitor
      logic        wm_prev;
      logic [31:0] pa, pd;
      wm_prev = 1'b0; pa = '0; pd = '0;
      forever begin
         @(negedge clk);
         if (resetq) begin
            if (spi_we) we_cnt++;
            if (spi_ss_reset) ss_cnt++;
            if (done) begin done_cnt++; ab_at_done = aborted; end
            if (mem_wmask == 4'hF) begin
               wm_cycles++;
               if (wm_prev && (mem_addr !== pa || mem_wdata !== pd)) unstable++;
               wm_prev = 1'b1; pa = mem_addr; pd = mem_wdata;
               if (!mem_wbusy) begin
                  wr_addr.push_back(mem_addr);
                  wr_data.push_back(mem_wdata);
                  wm_prev = 1'b0;
               end
            end else begin
               wm_prev = 1'b0;
            end
         end else begin
            wm_prev = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic start_copy(input logic [23:0] s, input logic [31:0] d,
                             input logic [LEN_W-1:0] l);
      spi_log.delete(); wr_addr.delete(); wr_data.delete();
      done_cnt = 0; ss_cnt = 0; we_cnt = 0; wm_cycles = 0; unstable = 0;
      ab_at_done = 1'b0;
      fl_addr = s;
      @(posedge clk); #1;
      src_addr = s; dst_addr = d; len_words = l; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset;
      logic [87:0] outs;
      #1 resetq = 1'b0;
      repeat (3) @(negedge clk);
      outs = {busy, done, aborted, spi_we, spi_di, spi_ss_reset, mem_addr, mem_wdata, mem_wmask};
      n_checks++;
      if (outs !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h want 0", outs);
      end
      @(posedge clk); #1 resetq = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, done, mem_wmask} !== 6'd0) begin
         n_fail++; $display("FAIL reset_release_idle: got %b want 0", {busy, done, mem_wmask});
      end
   endtask

   task automatic test_copy;
      bit ok;
      logic [7:0] exp_b[$];
      fl_base = 24'h100000; fl_seed = 8'h00; spi_slow = 1'b1; wb_rand = 1'b0;
      start_copy(24'h100000, 32'h00020000, 2);
      @(negedge clk);
      n_checks++;
      if (spi_we !== 1'b1) begin
         n_fail++; $display("FAIL copy_first_we_latency: got %b want 1", spi_we);
      end
      wait_done(500, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL copy_done_timeout: got none want done"); end
      exp_b = '{8'h03, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00};
      n_checks++;
      if (spi_log.size() != exp_b.size()) begin
         n_fail++; $display("FAIL copy_spi_count: got %0d want %0d", spi_log.size(), exp_b.size());
      end else begin
         for (int k = 0; k < exp_b.size(); k++) begin
            n_checks++;
            if (spi_log[k] !== exp_b[k]) begin
               n_fail++; $display("FAIL copy_spi_byte%0d: got %h want %h", k, spi_log[k], exp_b[k]);
            end
         end
      end
      n_checks++;
      if (wr_addr.size() != 2) begin
         n_fail++; $display("FAIL copy_write_count: got %0d want 2", wr_addr.size());
      end else begin
         n_checks++;
         if (wr_addr[0] !== 32'h00020000 || wr_data[0] !== 32'h44332211) begin
            n_fail++; $display("FAIL copy_write0: got %h@%h want 44332211@00020000", wr_data[0], wr_addr[0]);
         end
         n_checks++;
         if (wr_addr[1] !== 32'h00020004 || wr_data[1] !== 32'h88776655) begin
            n_fail++; $display("FAIL copy_write1: got %h@%h want 88776655@00020004", wr_data[1], wr_addr[1]);
         end
      end
      n_checks++;
      if (done_cnt != 1 || ab_at_done !== 1'b0 || ss_cnt != 1) begin
         n_fail++; $display("FAIL copy_status: got done=%0d aborted=%b ss=%0d want 1 0 1",
                            done_cnt, ab_at_done, ss_cnt);
      end
   endtask

   task automatic test_len0;
      start_copy(24'h000123, 32'h00001000, 0);
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL len0_done_early: got %b want 0", done); end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL len0_done_at_2: got %b want 1", done); end
      repeat (3) @(negedge clk);
      n_checks++;
      if (we_cnt != 0 || ss_cnt != 0 || done_cnt != 1 || wr_addr.size() != 0) begin
         n_fail++; $display("FAIL len0_activity: got we=%0d ss=%0d done=%0d wr=%0d want 0 0 1 0",
                            we_cnt, ss_cnt, done_cnt, wr_addr.size());
      end
   endtask

   task automatic test_wbusy;
      bit ok;
      logic [31:0] exp_w;
      fl_base = 24'h003000; fl_seed = 8'hA5; spi_slow = 1'b0; wb_rand = 1'b0;
      stall_left = 5;
      start_copy(24'h003000, 32'h00008000, 1);
      wait_done(500, ok);
      for (int b = 0; b < 4; b++) exp_w[8*b +: 8] = fb(24'h003000 + 24'(b));
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL wbusy_done_timeout: got none want done"); end
      n_checks++;
      if (wm_cycles != 6 || unstable != 0) begin
         n_fail++; $display("FAIL wbusy_hold: got cycles=%0d unstable=%0d want 6 0", wm_cycles, unstable);
      end
      n_checks++;
      if (wr_addr.size() != 1 || wr_addr[0] !== 32'h00008000 || wr_data[0] !== exp_w) begin
         n_fail++; $display("FAIL wbusy_commit: got n=%0d %h@%h want 1 %h@00008000",
                            wr_addr.size(), wr_data[0], wr_addr[0], exp_w);
      end
   endtask

   task automatic test_abort_data;
      bit ok, got;
      fl_base = 24'h000000; fl_seed = 8'h3C; spi_slow = 1'b1; wb_rand = 1'b0;
      start_copy(24'h000010, 32'h00004000, 4);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (spi_log.size() >= 6) begin got = 1'b1; break; end
      end
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      wait_done(300, ok);
      n_checks++;
      if (!got || !ok) begin
         n_fail++; $display("FAIL abort_data_progress: got reach=%b done=%b want 1 1", got, ok);
      end
      n_checks++;
      if (spi_log.size() != 6 || wr_addr.size() != 0) begin
         n_fail++; $display("FAIL abort_data_traffic: got bytes=%0d writes=%0d want 6 0",
                            spi_log.size(), wr_addr.size());
      end
      n_checks++;
      if (done_cnt != 1 || ab_at_done !== 1'b1 || aborted !== 1'b1) begin
         n_fail++; $display("FAIL abort_data_status: got done=%0d aborted=%b held=%b want 1 1 1",
                            done_cnt, ab_at_done, aborted);
      end
   endtask

   task automatic test_abort_write;
      bit ok, got;
      fl_base = 24'h000500; fl_seed = 8'h77; spi_slow = 1'b0; wb_rand = 1'b0;
      stall_left = 4;
      start_copy(24'h000500, 32'h00006000, 1);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (wm_cycles >= 1) begin got = 1'b1; break; end
      end
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      wait_done(300, ok);
      n_checks++;
      if (!got || !ok || wr_addr.size() != 1) begin
         n_fail++; $display("FAIL abort_write_commit: got reach=%b done=%b writes=%0d want 1 1 1",
                            got, ok, wr_addr.size());
      end
      n_checks++;
      if (done_cnt != 1 || ab_at_done !== 1'b1) begin
         n_fail++; $display("FAIL abort_write_status: got done=%0d aborted=%b want 1 1", done_cnt, ab_at_done);
      end
   endtask

   task automatic test_reset_mid;
      bit ok, got;
      logic [87:0] outs;
      logic [31:0] exp_w;
      fl_base = 24'h000400; fl_seed = 8'h5A; spi_slow = 1'b1; wb_rand = 1'b0;
      start_copy(24'h000400, 32'h00001000, 3);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (spi_log.size() >= 6) begin got = 1'b1; break; end
      end
      #2 resetq = 1'b0;
      #1;
      outs = {busy, done, aborted, spi_we, spi_di, spi_ss_reset, mem_addr, mem_wdata, mem_wmask};
      n_checks++;
      if (!got || outs !== '0) begin
         n_fail++; $display("FAIL reset_mid_outputs: got reach=%b outs=%h want 1 0", got, outs);
      end
      repeat (2) @(posedge clk);
      #1 resetq = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++;
      if (done_cnt != 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d want 0", done_cnt); end
      start_copy(24'h000400, 32'h00001100, 1);
      wait_done(300, ok);
      for (int b = 0; b < 4; b++) exp_w[8*b +: 8] = fb(24'h000400 + 24'(b));
      n_checks++;
      if (!ok || wr_addr.size() != 1 || wr_addr[0] !== 32'h00001100 || wr_data[0] !== exp_w) begin
         n_fail++; $display("FAIL reset_mid_recover: got done=%b n=%0d %h@%h want 1 1 %h@00001100",
                            ok, wr_addr.size(), wr_data[0], wr_addr[0], exp_w);
      end
   endtask

   task automatic test_start_busy;
      bit ok;
      logic [31:0] exp_w;
      fl_base = 24'h070000; fl_seed = 8'h19; spi_slow = 1'b1; wb_rand = 1'b0;
      start_copy(24'h070000, 32'h00009000, 2);
      repeat (4) @(posedge clk);
      #1 src_addr = 24'h0ABCDE; dst_addr = 32'h0000F000; len_words = 3; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(600, ok);
      n_checks++;
      if (!ok || done_cnt != 1 || wr_addr.size() != 2 || spi_log.size() != 12) begin
         n_fail++; $display("FAIL start_busy_count: got done=%0d writes=%0d bytes=%0d want 1 2 12",
                            done_cnt, wr_addr.size(), spi_log.size());
      end
      for (int w = 0; w < 2; w++) begin
         for (int b = 0; b < 4; b++) exp_w[8*b +: 8] = fb(24'h070000 + 24'(4*w + b));
         n_checks++;
         if (wr_addr[w] !== 32'h00009000 + 32'(4*w) || wr_data[w] !== exp_w) begin
            n_fail++; $display("FAIL start_busy_write%0d: got %h@%h want %h@%h",
                               w, wr_data[w], wr_addr[w], exp_w, 32'h00009000 + 32'(4*w));
         end
      end
   endtask

   task automatic test_random;
      bit ok;
      logic [23:0] s;
      logic [31:0] d, exp_w;
      int l;
      spi_slow = 1'b1; wb_rand = 1'b1;
      for (int it = 0; it < 20; it++) begin
         s = 24'($urandom);
         if (it % 4 == 0) s = 24'hFFFFF8 | 24'($urandom_range(0, 7));
         d = {$urandom, 2'b00} >> 0;
         d = {d[31:2], 2'b00};
         if (it % 5 == 1) d = 32'hFFFFFFF8;
         l = $urandom_range(1, 4);
         fl_base = 24'($urandom); fl_seed = 8'($urandom);
         start_copy(s, d, LEN_W'(l));
         wait_done(2000, ok);
         n_checks++;
         if (!ok || done_cnt != 1 || ab_at_done !== 1'b0 || ss_cnt != 1) begin
            n_fail++; $display("FAIL rand%0d_status: got done=%b/%0d aborted=%b ss=%0d want 1/1 0 1",
                               it, ok, done_cnt, ab_at_done, ss_cnt);
         end
         n_checks++;
         if (spi_log.size() != 4 + 4*l || spi_log[0] !== 8'h03 || spi_log[1] !== s[23:16] ||
             spi_log[2] !== s[15:8] || spi_log[3] !== s[7:0]) begin
            n_fail++; $display("FAIL rand%0d_header: got n=%0d %h %h %h %h want %0d 03 %h",
                               it, spi_log.size(), spi_log[0], spi_log[1], spi_log[2], spi_log[3], 4 + 4*l, s);
         end
         n_checks++;
         if (wr_addr.size() != l) begin
            n_fail++; $display("FAIL rand%0d_write_count: got %0d want %0d", it, wr_addr.size(), l);
         end else begin
            for (int w = 0; w < l; w++) begin
               for (int b = 0; b < 4; b++) exp_w[8*b +: 8] = fb(s + 24'(4*w + b));
               n_checks++;
               if (wr_addr[w] !== d + 32'(4*w) || wr_data[w] !== exp_w) begin
                  n_fail++; $display("FAIL rand%0d_write%0d: got %h@%h want %h@%h",
                                     it, w, wr_data[w], wr_addr[w], exp_w, d + 32'(4*w));
               end
            end
         end
      end
      wb_rand = 1'b0;
   endtask

   initial begin
      test_reset();
      test_copy();
      test_len0();
      test_wbusy();
      test_abort_data();
      test_abort_write();
      test_reset_mid();
      test_start_busy();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
